// File: rtl/i2cs_bridge_pkg.sv
// Shared definitions for the I2C target to memory-bus bridge: FSM states,
// I2C acknowledge levels, write strobe and the pointer-to-byte-address mapping.
package i2cs_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_DROP
  } state_e;

  localparam logic       ACK        = 1'b0;
  localparam logic       NACK       = 1'b1;
  localparam logic [3:0] WSTRB_BYTE = 4'b0001;

  // One register byte per 32-bit word.
  function automatic logic [11:0] byte_addr(input logic [7:0] p);
    return {2'b00, p, 2'b00};
  endfunction

endpackage

// File: rtl/i2cs_filter.sv
// Pad conditioning for one open-drain line: 2-flop synchronizer, FILT-sample
// agreement filter, and registered rise/fall strobes aligned with the level.
module i2cs_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, rise_q, fall_q;
  logic [FILT-2:0] hist_q, hist_d;
  logic            settled;

  // The level flips only once sync2 and the FILT-1 samples before it agree.
  always_comb begin
    hist_d    = hist_q << 1;
    hist_d[0] = sync2_q;
    settled   = (hist_q == {(FILT-1){sync2_q}}) && (sync2_q != level_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= '1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      rise_q  <= settled & sync2_q;
      fall_q  <= settled & ~sync2_q;
      if (settled) level_q <= sync2_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2cs_bridge.sv
// I2C target that converts controller transfers into single-byte accesses on
// the mem_valid/mem_ready bus through an 8-bit auto-incrementing pointer.
module i2cs_bridge
  import i2cs_bridge_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         FILT     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output state_e      dbg_state_o
);

  logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;

  i2cs_filter #(.FILT(FILT)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .pad_i(scl_i),
    .level_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2cs_filter #(.FILT(FILT)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .pad_i(sda_i),
    .level_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  state_e      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d, ptr_q, ptr_d, rdata_q;
  logic        rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic        issue, issue_wr;
  logic [7:0]  issue_ptr, issue_byte, rx_byte;
  logic        start_det, stop_det;
  logic        mem_valid_q;
  logic [11:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        unused_rdata;

  assign start_det    = sda_fall & scl_f;
  assign stop_det     = sda_rise & scl_f;
  assign rx_byte      = {shift_q[6:0], sda_f};
  assign unused_rdata = ^mem_rdata[31:8];

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    issue      = 1'b0;
    issue_wr   = 1'b0;
    issue_ptr  = ptr_q;
    issue_byte = 8'h00;
    if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLV_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = rx_byte[0];
                  issue  = rx_byte[0];
                end else begin
                  state_d = ST_DROP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d = rx_byte;
              end else begin
                issue      = 1'b1;
                issue_wr   = 1'b1;
                issue_byte = rx_byte;
                ptr_d      = ptr_q + 8'd1;
              end
            end
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            // The ACK state follows its data state in the enum ordering.
            state_d  = state_e'(state_q + 4'd1);
            bitcnt_d = 4'd0;
            sda_oe_d = ~ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = 4'd0;
            if (rw_q) begin
              shift_d  = rdata_q;
              sda_oe_d = ~rdata_q[7];
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_PTR;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
            state_d  = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = ST_RDATA_ACK;
            end else begin
              shift_d  = shift_q << 1;
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_f == NACK) begin
              state_d = ST_DROP;
            end else begin
              ptr_d     = ptr_q + 8'd1;
              issue     = 1'b1;
              issue_ptr = ptr_q + 8'd1;
            end
          end else if (scl_fall) begin
            shift_d  = rdata_q;
            sda_oe_d = ~rdata_q[7];
            bitcnt_d = 4'd0;
            state_d  = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 4'd0;
      shift_q  <= 8'h00;
      ptr_q    <= 8'h00;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
    end
  end

  // Bus initiator runs independently of the FSM so STOP never aborts a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 12'h000;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      rdata_q     <= 8'h00;
    end else if (issue) begin
      mem_valid_q <= 1'b1;
      mem_addr_q  <= byte_addr(issue_ptr);
      mem_wdata_q <= {24'h0, issue_byte};
      mem_wstrb_q <= issue_wr ? WSTRB_BYTE : 4'b0000;
    end else if (mem_valid_q && mem_ready) begin
      mem_valid_q <= 1'b0;
      if (mem_wstrb_q == 4'b0000) rdata_q <= mem_rdata[7:0];
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign mem_valid   = mem_valid_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign dbg_state_o = state_q;

endmodule
